sprite_dma: RTL and testbench

- Upstream feeder of the sprite engine. Copies a 128-byte sprite attribute table from CPU work RAM into sprite RAM during vertical blank.
- Sprite RAM changes only while the sprite engine is not scanning visible lines. This prevents tearing and half-updated sprites.
- The CPU arms a transfer with a register write. The block requests the work-RAM bus, streams 32 sprites × 4 bytes, counts enabled sprites, and reports status.

---
 rtl/sprite_dma_if.sv | 31 +++
 rtl/sprite_dma.sv | 162 ++++++++++++++++
 tb/tb_sprite_dma.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sprite_dma_if.sv
// Work-RAM read bus and sprite RAM write port shared by the sprite DMA and its neighbours.
// master: the DMA side. slave: the work-RAM arbiter and sprite RAM side.
interface sprite_dma_if;
  logic        src_req;
  logic        src_gnt;
  logic [15:0] src_addr;
  logic [7:0]  src_data;
  logic [6:0]  spriteram_wr_addr;
  logic        spriteram_wr;
  logic [7:0]  spriteram_data_in;

  modport master (
    output src_req,
    output src_addr,
    output spriteram_wr_addr,
    output spriteram_wr,
    output spriteram_data_in,
    input  src_gnt,
    input  src_data
  );

  modport slave (
    input  src_req,
    input  src_addr,
    input  spriteram_wr_addr,
    input  spriteram_wr,
    input  spriteram_data_in,
    output src_gnt,
    output src_data
  );
endinterface

// File: rtl/sprite_dma.sv
// Sprite attribute DMA: copies the 128-byte sprite table from a work-RAM page into sprite RAM
// during vertical blank, counts enabled sprites and reports completion/abort status.
module sprite_dma #(
  parameter int unsigned SPR_COUNT = 32,
  parameter int unsigned SPR_BYTES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vblank,
  input  logic              ctrl_wr,
  input  logic [7:0]        ctrl_data,
  sprite_dma_if.master      bus,
  output logic              busy,
  output logic              done,
  output logic              abort_err,
  output logic [5:0]        spr_enabled_cnt
);

  localparam int unsigned XFER_LEN = SPR_COUNT * SPR_BYTES;
  localparam logic [6:0]  LastIdx  = 7'(XFER_LEN - 1);

  typedef enum logic [2:0] {StIdle, StArmed, StReq, StCopy, StDrain, StDone} state_e;

  state_e     state_q, state_d;
  logic [7:0] page_q, page_d;
  logic       armed_q, armed_d;
  logic       done_q, done_d;
  logic       abort_q, abort_d;
  logic [5:0] cnt_q, cnt_d;
  logic [5:0] acc_q, acc_d;
  logic [6:0] idx_q, idx_d;
  logic       wr_valid_q, wr_valid_d;
  logic [6:0] wr_addr_q, wr_addr_d;
  logic       vblank_q;

  logic vblank_rise;
  logic xfer_active;
  logic wr_is_enable;

  assign vblank_rise  = vblank & ~vblank_q;
  assign xfer_active  = (state_q == StReq) || (state_q == StCopy) || (state_q == StDrain);
  // Byte 0 of each entry carries the enable flag in bit 7.
  assign wr_is_enable = wr_valid_q && (wr_addr_q[1:0] == 2'b00) && bus.src_data[7];

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      page_q     <= 8'h00;
      armed_q    <= 1'b0;
      done_q     <= 1'b0;
      abort_q    <= 1'b0;
      cnt_q      <= 6'd0;
      acc_q      <= 6'd0;
      idx_q      <= 7'd0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= 7'd0;
      vblank_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      page_q     <= page_d;
      armed_q    <= armed_d;
      done_q     <= done_d;
      abort_q    <= abort_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      idx_q      <= idx_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      vblank_q   <= vblank;
    end
  end

  // Next-state logic: arming, vblank-gated request, copy pipeline and abort handling.
  always_comb begin
    state_d    = state_q;
    page_d     = page_q;
    armed_d    = armed_q;
    done_d     = done_q;
    abort_d    = abort_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q + {5'd0, wr_is_enable};
    idx_d      = idx_q;
    wr_valid_d = 1'b0;
    wr_addr_d  = wr_addr_q;

    unique case (state_q)
      StIdle: begin
        if (ctrl_wr) begin
          page_d  = ctrl_data;
          armed_d = 1'b1;
          done_d  = 1'b0;
          abort_d = 1'b0;
          state_d = StArmed;
        end
      end
      StArmed: begin
        if (ctrl_wr) page_d = ctrl_data;
        // Only a fresh rising edge starts a copy, never the middle of a blank.
        if (vblank_rise) state_d = StReq;
      end
      StReq: begin
        if (!vblank) begin
          abort_d = 1'b1;
          state_d = StArmed;
        end else if (bus.src_gnt) begin
          idx_d   = 7'd0;
          acc_d   = 6'd0;
          state_d = StCopy;
        end
      end
      StCopy: begin
        if (!vblank) begin
          // The byte whose read is in flight this cycle is dropped.
          abort_d = 1'b1;
          state_d = StArmed;
        end else begin
          wr_valid_d = 1'b1;
          wr_addr_d  = idx_q;
          idx_d      = idx_q + 7'd1;
          if (idx_q == LastIdx) state_d = StDrain;
        end
      end
      StDrain: begin
        if (!vblank) begin
          abort_d = 1'b1;
          state_d = StArmed;
        end else begin
          state_d = StDone;
        end
      end
      StDone: begin
        cnt_d   = acc_q;
        done_d  = 1'b1;
        abort_d = 1'b0;
        armed_d = 1'b0;
        state_d = StIdle;
        // A strobe landing here re-arms immediately; the completed flag stays visible.
        if (ctrl_wr) begin
          page_d  = ctrl_data;
          armed_d = 1'b1;
          state_d = StArmed;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Bus and status outputs; data/address are forced to zero when not in use.
  always_comb begin
    bus.src_req           = xfer_active;
    bus.src_addr          = (state_q == StCopy) ? ({page_q, 8'h00} + {9'd0, idx_q}) : 16'h0000;
    bus.spriteram_wr      = wr_valid_q;
    bus.spriteram_wr_addr = wr_valid_q ? wr_addr_q : 7'd0;
    bus.spriteram_data_in = wr_valid_q ? bus.src_data : 8'h00;
    busy                  = armed_q | xfer_active;
    done                  = done_q;
    abort_err             = abort_q;
    spr_enabled_cnt       = cnt_q;
  end

endmodule

// File: tb/tb_sprite_dma.sv
// Scoreboard bench for sprite_dma: expected sprite RAM writes are queued when a transfer is
// launched and a negedge monitor pops and compares every write the DUT presents.
module tb_sprite_dma;

  logic       clk = 1'b0;
  logic       reset;
  logic       vblank;
  logic       ctrl_wr;
  logic [7:0] ctrl_data;
  logic       busy;
  logic       done;
  logic       abort_err;
  logic [5:0] spr_enabled_cnt;

  sprite_dma_if bus ();

  sprite_dma dut (
    .clk             (clk),
    .reset           (reset),
    .vblank          (vblank),
    .ctrl_wr         (ctrl_wr),
    .ctrl_data       (ctrl_data),
    .bus             (bus),
    .busy            (busy),
    .done            (done),
    .abort_err       (abort_err),
    .spr_enabled_cnt (spr_enabled_cnt)
  );

  always #5 clk = ~clk;

  logic [7:0]  wram [0:65535];
  logic [14:0] exp_q [$];
  logic [14:0] sb_e;
  int          errors = 0;
  int          checks = 0;
  int          wr_cnt = 0;

  // Work RAM: synchronous read, data valid one cycle after the address.
  always @(posedge clk) bus.src_data <= wram[bus.src_addr];

  // Write monitor / scoreboard.
  always @(negedge clk) begin
    if (bus.spriteram_wr === 1'b1) begin
      wr_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr=%0d data=%02h, required no write",
                 bus.spriteram_wr_addr, bus.spriteram_data_in);
      end else begin
        sb_e = exp_q.pop_front();
        if ({bus.spriteram_wr_addr, bus.spriteram_data_in} !== sb_e) begin
          errors++;
          $display("FAIL write_match: got addr=%0d data=%02h, required addr=%0d data=%02h",
                   bus.spriteram_wr_addr, bus.spriteram_data_in, sb_e[14:8], sb_e[7:0]);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic arm(input logic [7:0] page);
    ctrl_data = page;
    ctrl_wr   = 1'b1;
    tick();
    ctrl_wr   = 1'b0;
  endtask

  task automatic push_table(input logic [7:0] page);
    for (int i = 0; i < 128; i++) exp_q.push_back({7'(i), wram[{page, 8'h00} + 16'(i)]});
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (done !== 1'b1 && n < 600) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(done), 32'd1);
  endtask

  task automatic wait_addr(input string name, input logic [15:0] a);
    int n = 0;
    while (bus.src_addr !== a && n < 600) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(bus.src_addr), 32'(a));
  endtask

  task automatic wait_req(input string name);
    int n = 0;
    while (bus.src_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(bus.src_req), 32'd1);
  endtask

  // Full transfer with the grant tied high; checks final status and enabled count.
  task automatic run_xfer(input string name, input logic [7:0] page, input int exp_cnt);
    push_table(page);
    arm(page);
    vblank = 1'b1;
    wait_done({name, "_done"});
    check({name, "_busy"}, 32'(busy), 32'd0);
    check({name, "_abort"}, 32'(abort_err), 32'd0);
    check({name, "_cnt"}, 32'(spr_enabled_cnt), 32'(exp_cnt));
    tick();
    vblank = 1'b0;
    repeat (3) tick();
    check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  int n;
  int req_cycles;
  int start_wr;
  int activity;
  logic [15:0] first_addr;

  initial begin
    for (int a = 0; a < 65536; a++) wram[a] = 8'h00;
    for (int i = 0; i < 128; i++) begin
      wram[16'h4000 + 16'(i)] = 8'(i) ^ 8'h5A;
      wram[16'hFF00 + 16'(i)] = ~8'(i);
      wram[16'h1000 + 16'(i)] = 8'hFF ^ 8'(i);
    end
    for (int e = 0; e < 32; e++) begin
      wram[16'h2000 + 16'(4 * e)] = ((e == 0 || e == 5 || e == 31) ? 8'h80 : 8'h00) | 8'(e % 16);
      wram[16'h2001 + 16'(4 * e)] = 8'h80 | 8'(e);
      wram[16'h2002 + 16'(4 * e)] = 8'hC3;
      wram[16'h2003 + 16'(4 * e)] = 8'h80 | 8'(3 * e);
      wram[16'h2100 + 16'(4 * e)] = 8'h80 | 8'(e % 16);
      wram[16'h2101 + 16'(4 * e)] = 8'hFF;
      wram[16'h2102 + 16'(4 * e)] = 8'h40;
      wram[16'h2103 + 16'(4 * e)] = 8'(e);
    end

    reset       = 1'b1;
    vblank      = 1'b0;
    ctrl_wr     = 1'b0;
    ctrl_data   = 8'h00;
    bus.src_gnt = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    @(negedge clk);
    check("rst_src_req", 32'(bus.src_req), 32'd0);
    check("rst_wr", 32'(bus.spriteram_wr), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_flags", {30'd0, done, abort_err}, 32'd0);
    check("rst_cnt", 32'(spr_enabled_cnt), 32'd0);

    // Unarmed: three frames of vblank must not start anything.
    req_cycles = 0;
    for (int f = 0; f < 3; f++) begin
      tick();
      vblank = 1'b1;
      repeat (20) begin
        @(negedge clk);
        if (bus.src_req === 1'b1) req_cycles++;
      end
      tick();
      vblank = 1'b0;
      repeat (20) begin
        @(negedge clk);
        if (bus.src_req === 1'b1) req_cycles++;
      end
    end
    check("unarmed_req", 32'(req_cycles), 32'd0);
    check("unarmed_writes", 32'(wr_cnt), 32'd0);
    check("unarmed_done", 32'(done), 32'd0);

    // Page 0x40, grant tied high: src_req must be high for exactly 130 cycles.
    bus.src_gnt = 1'b1;
    tick();
    push_table(8'h40);
    arm(8'h40);
    @(negedge clk);
    check("arm_busy", 32'(busy), 32'd1);
    check("arm_done", 32'(done), 32'd0);
    tick();
    vblank = 1'b1;
    wait_req("t1_req_rise");
    req_cycles = 0;
    while (bus.src_req === 1'b1 && req_cycles < 300) begin
      req_cycles++;
      @(negedge clk);
    end
    check("t1_req_len", 32'(req_cycles), 32'd130);
    wait_done("t1_done");
    check("t1_busy", 32'(busy), 32'd0);
    check("t1_writes", 32'(wr_cnt), 32'd128);
    check("t1_cnt", 32'(spr_enabled_cnt), 32'd0);
    tick();
    vblank = 1'b0;
    repeat (3) tick();
    check("t1_drained", 32'(exp_q.size()), 32'd0);

    // Grant withheld for 50 cycles after the request.
    bus.src_gnt = 1'b0;
    push_table(8'h40);
    arm(8'h40);
    vblank = 1'b1;
    wait_req("t4_req_rise");
    activity = 0;
    repeat (50) begin
      @(negedge clk);
      if (bus.src_addr !== 16'h0000 || bus.spriteram_wr !== 1'b0) activity++;
    end
    check("t4_no_activity", 32'(activity), 32'd0);
    bus.src_gnt = 1'b1;
    n = 0;
    first_addr = 16'h0000;
    while (n < 10) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (n == 1) first_addr = bus.src_addr;
      if (bus.spriteram_wr === 1'b1) break;
    end
    check("t4_first_addr", 32'(first_addr), 32'h4000);
    check("t4_write_latency", 32'(n), 32'd2);
    check("t4_first_wr_addr", 32'(bus.spriteram_wr_addr), 32'd0);
    wait_done("t4_done");
    tick();
    vblank = 1'b0;
    repeat (3) tick();
    check("t4_drained", 32'(exp_q.size()), 32'd0);

    // Enabled-sprite counting: entries 0, 5, 31, then all 32.
    run_xfer("cnt3", 8'h20, 3);
    run_xfer("cnt32", 8'h21, 32);

    // vblank falls while idx 60 is issued.
    start_wr = wr_cnt;
    push_table(8'h40);
    arm(8'h40);
    vblank = 1'b1;
    wait_addr("t5_reach_idx60", 16'h403C);
    vblank = 1'b0;
    repeat (5) @(negedge clk);
    check("t5_write_bound", 32'((wr_cnt - start_wr) <= 61), 32'd1);
    check("t5_abort_err", 32'(abort_err), 32'd1);
    check("t5_busy", 32'(busy), 32'd1);
    check("t5_done", 32'(done), 32'd0);
    check("t5_src_req", 32'(bus.src_req), 32'd0);
    check("t5_cnt_kept", 32'(spr_enabled_cnt), 32'd32);
    exp_q.delete();
    push_table(8'h40);
    tick();
    vblank = 1'b1;
    wait_done("t5_retry_done");
    check("t5_retry_abort", 32'(abort_err), 32'd0);
    check("t5_retry_busy", 32'(busy), 32'd0);
    check("t5_retry_cnt", 32'(spr_enabled_cnt), 32'd0);
    tick();
    vblank = 1'b0;
    repeat (3) tick();
    check("t5_drained", 32'(exp_q.size()), 32'd0);

    // Top page: 0xFF00..0xFF7F, every entry enabled.
    run_xfer("page_ff", 8'hFF, 32);

    // Reset in the middle of a copy.
    push_table(8'h40);
    arm(8'h40);
    vblank = 1'b1;
    wait_addr("t6_reach_idx20", 16'h4014);
    reset = 1'b1;
    @(negedge clk);
    check("t6_rst_src_req", 32'(bus.src_req), 32'd0);
    check("t6_rst_wr", 32'(bus.spriteram_wr), 32'd0);
    check("t6_rst_addr", 32'(bus.src_addr), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_flags", {30'd0, done, abort_err}, 32'd0);
    check("t6_rst_cnt", 32'(spr_enabled_cnt), 32'd0);
    exp_q.delete();
    tick();
    reset  = 1'b0;
    vblank = 1'b0;
    repeat (2) tick();

    // ctrl_wr during COPY must not change the source page.
    push_table(8'h40);
    arm(8'h40);
    vblank = 1'b1;
    wait_addr("t6_reach_idx10", 16'h400A);
    ctrl_data = 8'h10;
    ctrl_wr   = 1'b1;
    @(negedge clk);
    ctrl_wr = 1'b0;
    check("t6_page_kept", 32'(bus.src_addr[15:8]), 32'h40);
    wait_done("t6_done");
    check("t6_busy", 32'(busy), 32'd0);
    tick();
    vblank = 1'b0;
    repeat (3) tick();
    check("t6_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
